// File: rtl/inv_pkg.sv
// Shared codes for the tag inventory sequencer: tag states, reply kinds,
// command-vector bit positions and the slot-number mask helper.
package inv_pkg;

    typedef enum logic [2:0] {
        ST_READY     = 3'd0,
        ST_ARBITRATE = 3'd1,
        ST_REPLY     = 3'd2,
        ST_ACKED     = 3'd3,
        ST_OPEN      = 3'd4
    } tag_state_t;

    typedef enum logic [2:0] {
        RP_NONE   = 3'd0,
        RP_RN16   = 3'd1,
        RP_EPC    = 3'd2,
        RP_HANDLE = 3'd3,
        RP_DATA   = 3'd4
    } reply_t;

    localparam int CMD_QUERYREP = 0;
    localparam int CMD_ACK      = 1;
    localparam int CMD_QUERY    = 2;
    localparam int CMD_QUERYADJ = 3;
    localparam int CMD_SELECT   = 4;
    localparam int CMD_NAK      = 5;
    localparam int CMD_REQRN    = 6;
    localparam int CMD_ACC_LO   = 7;
    localparam int CMD_ACC_HI   = 13;
    localparam int CMD_W        = 14;

    localparam int SLOT_W = 15;
    localparam int Q_W    = 4;

    // Slot number is the low Q bits of the random value; Q=15 keeps all 15.
    function automatic logic [SLOT_W-1:0] slot_mask(input logic [SLOT_W-1:0] rng,
                                                    input logic [Q_W-1:0] q);
        logic [15:0] m;
        m = (16'd1 << q) - 16'd1;
        return rng & m[SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/inv_slot_ctr.sv
// Q register and 15-bit slot counter. o_nxt_zero reports the slot value that
// will be stored this cycle so the sequencer can branch in the same decision.
module inv_slot_ctr
    import inv_pkg::*;
#(
    parameter int Q_INIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [Q_W-1:0]    i_q_load,
    input  logic              i_adj,
    input  logic [1:0]        i_adj_dir,
    input  logic              i_dec,
    input  logic [SLOT_W-1:0] i_rng,
    output logic [Q_W-1:0]    o_q,
    output logic              o_slot_zero,
    output logic              o_nxt_zero
);

    logic [Q_W-1:0]    r_q;
    logic [SLOT_W-1:0] r_slot;
    logic              r_slot_zero;
    logic [Q_W-1:0]    w_q_nxt;
    logic [SLOT_W-1:0] w_slot_nxt;

    always_comb begin
        w_q_nxt = r_q;
        if (i_load) begin
            w_q_nxt = i_q_load;
        end else if (i_adj) begin
            if (i_adj_dir == 2'b11 && r_q != 4'd15)
                w_q_nxt = r_q + 4'd1;
            else if (i_adj_dir == 2'b01 && r_q != 4'd0)
                w_q_nxt = r_q - 4'd1;
        end
    end

    // Decrement wraps 0 -> 0x7FFF through natural 15-bit arithmetic.
    always_comb begin
        w_slot_nxt = r_slot;
        if (i_load || i_adj)
            w_slot_nxt = slot_mask(i_rng, w_q_nxt);
        else if (i_dec)
            w_slot_nxt = r_slot - 15'd1;
    end

    assign o_nxt_zero = (w_slot_nxt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= Q_W'(Q_INIT);
            r_slot      <= 15'h7FFF;
            r_slot_zero <= 1'b0;
        end else begin
            r_q         <= w_q_nxt;
            r_slot      <= w_slot_nxt;
            r_slot_zero <= (w_slot_nxt == '0);
        end
    end

    assign o_q         = r_q;
    assign o_slot_zero = r_slot_zero;

endmodule

// File: rtl/inv_state_ctrl.sv
// Tag-side inventory/access sequencer: reacts to parsed packets, tracks the
// Gen2 tag state, picks the reply for TX and resets the parser between packets.
module inv_state_ctrl
    import inv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096,
    parameter int Q_INIT      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_done,
    input  logic [CMD_W-1:0]  cmd_out,
    input  logic              crc5invalid,
    input  logic              crc16invalid,
    input  logic [Q_W-1:0]    q_query,
    input  logic [1:0]        qadj_dir,
    input  logic [15:0]       rng,
    input  logic              ack_match,
    input  logic              handle_match,
    input  logic              tx_done,
    output logic [2:0]        tag_state,
    output logic [2:0]        reply_type,
    output logic              tx_start,
    output logic              parser_reset,
    output logic [Q_W-1:0]    q_out,
    output logic              slot_zero
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    tag_state_t r_state, w_state_nxt;
    reply_t     r_reply, w_reply_sel, w_reply_nxt;
    logic       r_tx_start, r_parser_reset, r_tx_busy, r_pkt_d;
    logic       r_tmr_on;
    logic [TW-1:0] r_timer;

    logic w_edge, w_valid, w_tx_fin, w_timeout, w_busy_nxt, w_prst_nxt;
    logic w_c_query, w_c_adj, w_c_rep, w_c_ack, w_c_nak, w_c_reqrn, w_c_acc, w_c_sel;
    logic w_ld, w_adj, w_dec, w_nxt_zero;
    logic w_unused_rng;

    assign w_unused_rng = rng[15];

    // Packet edges are dropped while a reply is still going out.
    assign w_edge   = pkt_done & ~r_pkt_d & ~r_tx_busy;
    assign w_valid  = w_edge & ~crc5invalid & ~crc16invalid & (|cmd_out);
    assign w_tx_fin = tx_done & r_tx_busy;
    assign w_timeout = r_tmr_on && (r_timer == TW'(TIMEOUT_CYC));

    // Priority decode so a stray multi-hot vector still maps to one command.
    assign w_c_query = cmd_out[CMD_QUERY];
    assign w_c_adj   = ~w_c_query & cmd_out[CMD_QUERYADJ];
    assign w_c_rep   = ~w_c_query & ~cmd_out[CMD_QUERYADJ] & cmd_out[CMD_QUERYREP];
    assign w_c_ack   = ~(|cmd_out[3:2]) & ~cmd_out[CMD_QUERYREP] & cmd_out[CMD_ACK];
    assign w_c_nak   = ~(|cmd_out[3:0]) & cmd_out[CMD_NAK];
    assign w_c_reqrn = ~(|cmd_out[3:0]) & ~cmd_out[CMD_NAK] & cmd_out[CMD_REQRN];
    assign w_c_acc   = ~(|cmd_out[3:0]) & ~(|cmd_out[6:5]) & (|cmd_out[CMD_ACC_HI:CMD_ACC_LO]);
    assign w_c_sel   = ~(|cmd_out[3:0]) & ~(|cmd_out[CMD_ACC_HI:5]) & cmd_out[CMD_SELECT];

    assign w_ld  = w_valid & w_c_query;
    assign w_adj = w_valid & w_c_adj & (r_state != ST_READY);
    assign w_dec = w_valid & w_c_rep & (r_state == ST_ARBITRATE);

    inv_slot_ctr #(.Q_INIT(Q_INIT)) u_slot (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ld),
        .i_q_load    (q_query),
        .i_adj       (w_adj),
        .i_adj_dir   (qadj_dir),
        .i_dec       (w_dec),
        .i_rng       (rng[SLOT_W-1:0]),
        .o_q         (q_out),
        .o_slot_zero (slot_zero),
        .o_nxt_zero  (w_nxt_zero)
    );

    // Next-state and reply selection.
    always_comb begin
        w_state_nxt = r_state;
        w_reply_sel = RP_NONE;
        if (w_valid) begin
            if (w_ld || w_adj) begin
                w_state_nxt = w_nxt_zero ? ST_REPLY : ST_ARBITRATE;
                w_reply_sel = w_nxt_zero ? RP_RN16 : RP_NONE;
            end else if (w_c_rep) begin
                case (r_state)
                    ST_READY: ;
                    ST_ARBITRATE: if (w_nxt_zero) begin
                        w_state_nxt = ST_REPLY;
                        w_reply_sel = RP_RN16;
                    end
                    default: w_state_nxt = ST_ARBITRATE;
                endcase
            end else if (w_c_ack) begin
                case (r_state)
                    ST_REPLY, ST_ACKED: begin
                        w_state_nxt = ack_match ? ST_ACKED : ST_ARBITRATE;
                        w_reply_sel = ack_match ? RP_EPC : RP_NONE;
                    end
                    ST_OPEN: begin
                        w_state_nxt = ack_match ? ST_OPEN : ST_ARBITRATE;
                        w_reply_sel = ack_match ? RP_EPC : RP_NONE;
                    end
                    default: ;
                endcase
            end else if (w_c_nak) begin
                if (r_state != ST_READY)
                    w_state_nxt = ST_ARBITRATE;
            end else if (w_c_reqrn) begin
                if ((r_state == ST_ACKED || r_state == ST_OPEN) && handle_match) begin
                    w_state_nxt = ST_OPEN;
                    w_reply_sel = RP_HANDLE;
                end
            end else if (w_c_acc) begin
                if (r_state == ST_OPEN && handle_match)
                    w_reply_sel = RP_DATA;
            end else if (w_c_sel) begin
                w_state_nxt = ST_READY;
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_ARBITRATE;
        end
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        w_busy_nxt  = r_tx_busy;
        w_reply_nxt = r_reply;
        if (w_reply_sel != RP_NONE) begin
            w_busy_nxt  = 1'b1;
            w_reply_nxt = w_reply_sel;
        end else if (w_tx_fin) begin
            w_busy_nxt  = 1'b0;
            w_reply_nxt = RP_NONE;
        end
        w_prst_nxt = w_edge | w_busy_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_READY;
            r_reply        <= RP_NONE;
            r_tx_start     <= 1'b0;
            r_parser_reset <= 1'b1;
            r_tx_busy      <= 1'b0;
            r_pkt_d        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_reply        <= w_reply_nxt;
            r_tx_start     <= (w_reply_sel != RP_NONE);
            r_parser_reset <= w_prst_nxt;
            r_tx_busy      <= w_busy_nxt;
            r_pkt_d        <= pkt_done;
        end
    end

    // Reply timer: a valid packet on the limit cycle takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr_on <= 1'b0;
            r_timer  <= '0;
        end else if (w_valid || w_timeout) begin
            r_tmr_on <= 1'b0;
            r_timer  <= '0;
        end else if (w_tx_fin && (r_state == ST_REPLY || r_state == ST_ACKED)) begin
            r_tmr_on <= 1'b1;
            r_timer  <= TW'(1);
        end else if (r_tmr_on) begin
            r_timer  <= r_timer + TW'(1);
        end
    end

    assign tag_state    = r_state;
    assign reply_type   = r_reply;
    assign tx_start     = r_tx_start;
    assign parser_reset = r_parser_reset;

endmodule
